// File: rtl/lane_car_queue.sv
// rtl/lane_car_queue.sv - waiting-car queue and paced intersection discharge for one approach
//
// Absorbs the per-cycle arrival strobe, tracks the number of cars waiting and
// releases them through the intersection one at a time while the light is green.
// Each car occupies the intersection for DEPART_CYCLES cycles, followed by
// GAP_CYCLES cycles of headway before the next car may enter.
//
// Optional build macro: LANE_CAR_QUEUE_DROP_COUNT_EN adds a saturating count
// of arrivals dropped because the queue was full.
//
// Ports:
//   traffic_clk  in   traffic clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   add_car      in   arrival strobe, one car per cycle sampled high
//   light_green  in   this approach's light is green
//   car_count    out  cars waiting (excludes the car in the intersection)
//   car_waiting  out  car_count != 0
//   queue_full   out  car_count == MAX_CARS
//   car_depart   out  one-cycle pulse per car cleared
//   cars_passed  out  total departures, wraps at 256
//   drop_count   out  dropped arrivals, saturating (macro builds only)

module lane_car_queue #(
    parameter int MAX_CARS      = 15,
    parameter int CNT_W         = 4,
    parameter int DEPART_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic             traffic_clk,
    input  logic             reset_n,
    input  logic             add_car,
    input  logic             light_green,
    output logic [CNT_W-1:0] car_count,
    output logic             car_waiting,
    output logic             queue_full,
    output logic             car_depart,
    output logic [7:0]       cars_passed
`ifdef LANE_CAR_QUEUE_DROP_COUNT_EN
    ,
    output logic [7:0]       drop_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CROSS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // The timer counts down the remaining cycles of the current phase, so it
    // never needs to hold more than the longest phase length minus one.
    localparam int TMAX  = (DEPART_CYCLES > GAP_CYCLES) ? DEPART_CYCLES : GAP_CYCLES;
    localparam int TMR_W = (TMAX < 2) ? 1 : $clog2(TMAX);

    localparam logic [TMR_W-1:0] DEP_LOAD = TMR_W'(DEPART_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CARS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               depart_q, depart_d;
    logic [7:0]         passed_q, passed_d;

    logic               can_enter;
    logic               take;
    logic               accept;

    assign can_enter = light_green && (count_q != '0);

    // Phase sequencing. A car committed to CROSS always completes, so
    // light_green is only consulted at entry decisions.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        take     = 1'b0;
        depart_d = 1'b0;
        passed_d = passed_q;

        case (state_q)
            S_IDLE: begin
                if (can_enter) begin
                    state_d = S_CROSS;
                    timer_d = DEP_LOAD;
                    take    = 1'b1;
                end
            end

            S_CROSS: begin
                if (timer_q == '0) begin
                    depart_d = 1'b1;
                    passed_d = passed_q + 8'd1;
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        timer_d = GAP_LOAD;
                    end else if (can_enter) begin
                        state_d = S_CROSS;
                        timer_d = DEP_LOAD;
                        take    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            S_GAP: begin
                if (timer_q == '0) begin
                    if (can_enter) begin
                        state_d = S_CROSS;
                        timer_d = DEP_LOAD;
                        take    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // A car leaving for the intersection frees a slot on the same edge, so an
    // arrival at full is still accepted when it coincides with an entry.
    assign accept = add_car && ((count_q != MAX_CNT) || take);

    always_comb begin
        count_d = count_q;
        if (accept && !take) begin
            count_d = count_q + CNT_ONE;
        end else if (take && !accept) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge traffic_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            depart_q <= 1'b0;
            passed_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            depart_q <= depart_d;
            passed_q <= passed_d;
        end
    end

`ifdef LANE_CAR_QUEUE_DROP_COUNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (add_car && !accept && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge traffic_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

    assign car_count   = count_q;
    assign car_waiting = (count_q != '0);
    assign queue_full  = (count_q == MAX_CNT);
    assign car_depart  = depart_q;
    assign cars_passed = passed_q;

endmodule

// File: tb/tb_lane_car_queue.sv
// tb/tb_lane_car_queue.sv - self-checking bench for lane_car_queue

module tb_lane_car_queue;

    logic       traffic_clk;
    logic       reset_n;
    logic       add_car;
    logic       light_green;
    logic [3:0] car_count;
    logic       car_waiting;
    logic       queue_full;
    logic       car_depart;
    logic [7:0] cars_passed;
`ifdef LANE_CAR_QUEUE_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    lane_car_queue #(
        .MAX_CARS      (15),
        .CNT_W         (4),
        .DEPART_CYCLES (2),
        .GAP_CYCLES    (1)
    ) dut (
        .traffic_clk (traffic_clk),
        .reset_n     (reset_n),
        .add_car     (add_car),
        .light_green (light_green),
        .car_count   (car_count),
        .car_waiting (car_waiting),
        .queue_full  (queue_full),
        .car_depart  (car_depart),
        .cars_passed (cars_passed)
`ifdef LANE_CAR_QUEUE_DROP_COUNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    initial traffic_clk = 1'b0;
    always #5 traffic_clk = ~traffic_clk;

    typedef struct {
        logic       add;
        logic       green;
        logic [3:0] exp_count;
        logic       exp_depart;
        logic [7:0] exp_passed;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_errors;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void push(input logic a, input logic g, input int c,
                                 input logic d, input int p);
        vec_t v;
        v.add        = a;
        v.green      = g;
        v.exp_count  = 4'(c);
        v.exp_depart = d;
        v.exp_passed = 8'(p);
        vecs.push_back(v);
    endfunction

    task automatic check_state(input string tag, input int c, input logic d, input int p);
        check({tag, " car_count"},   int'(car_count),   c);
        check({tag, " car_waiting"}, int'(car_waiting), (c != 0) ? 1 : 0);
        check({tag, " queue_full"},  int'(queue_full),  (c == 15) ? 1 : 0);
        check({tag, " car_depart"},  int'(car_depart),  int'(d));
        check({tag, " cars_passed"}, int'(cars_passed), p);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step(input logic a, input logic g);
        add_car     = a;
        light_green = g;
        @(posedge traffic_clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].add, vecs[i].green);
            check_state($sformatf("%s[%0d]", tag, i), int'(vecs[i].exp_count),
                        vecs[i].exp_depart, int'(vecs[i].exp_passed));
        end
        vecs.delete();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        add_car     = 1'b0;
        light_green = 1'b0;
        repeat (2) @(posedge traffic_clk);
        #1;
        check_state("reset", 0, 1'b0, 0);
        reset_n = 1'b1;

        // Fill five cars on red, then discharge on steady green.
        for (int i = 1; i <= 5; i++) push(1'b1, 1'b0, i, 1'b0, 0);
        push(1'b0, 1'b1, 4, 1'b0, 0);
        push(1'b0, 1'b1, 4, 1'b0, 0);
        push(1'b0, 1'b1, 4, 1'b1, 1);
        push(1'b0, 1'b1, 3, 1'b0, 1);
        push(1'b0, 1'b1, 3, 1'b0, 1);
        push(1'b0, 1'b1, 3, 1'b1, 2);
        push(1'b0, 1'b1, 2, 1'b0, 2);
        push(1'b0, 1'b1, 2, 1'b0, 2);
        push(1'b0, 1'b1, 2, 1'b1, 3);
        push(1'b0, 1'b1, 1, 1'b0, 3);
        push(1'b0, 1'b1, 1, 1'b0, 3);
        push(1'b0, 1'b1, 1, 1'b1, 4);
        push(1'b0, 1'b1, 0, 1'b0, 4);
        push(1'b0, 1'b1, 0, 1'b0, 4);
        push(1'b0, 1'b1, 0, 1'b1, 5);
        push(1'b0, 1'b1, 0, 1'b0, 5);
        push(1'b0, 1'b1, 0, 1'b0, 5);
        run_table("drain");

        // Twenty arrivals on red saturate at capacity.
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("fill[%0d] car_count", i), int'(car_count), (i < 15) ? i : 15);
        end
        check("fill queue_full", int'(queue_full), 1);
        check("fill car_depart", int'(car_depart), 0);
`ifdef LANE_CAR_QUEUE_DROP_COUNT_EN
        check("fill drop_count", int'(drop_count), 5);
`endif

        // Full queue with arrivals held: each entry edge also accepts a car.
        push(1'b1, 1'b1, 15, 1'b0, 5);
        push(1'b1, 1'b1, 15, 1'b0, 5);
        push(1'b1, 1'b1, 15, 1'b1, 6);
        push(1'b1, 1'b1, 15, 1'b0, 6);
        push(1'b1, 1'b1, 15, 1'b0, 6);
        push(1'b1, 1'b1, 15, 1'b1, 7);
        push(1'b1, 1'b1, 15, 1'b0, 7);
        push(1'b1, 1'b1, 15, 1'b0, 7);
        push(1'b1, 1'b1, 15, 1'b1, 8);
        push(1'b1, 1'b1, 15, 1'b0, 8);
        push(1'b0, 1'b1, 15, 1'b0, 8);
        run_table("full");

        // Now mid-CROSS: reset asynchronously between edges.
        #2;
        reset_n = 1'b0;
        #1;
        check_state("async_rst", 0, 1'b0, 0);
        add_car     = 1'b0;
        light_green = 1'b1;
        @(posedge traffic_clk);
        #3;
        reset_n = 1'b1;
        @(negedge traffic_clk);
        check_state("post_rst", 0, 1'b0, 0);

        // After release: no stray depart; then a committed car completes on red.
        push(1'b0, 1'b1, 0, 1'b0, 0);
        push(1'b0, 1'b1, 0, 1'b0, 0);
        push(1'b1, 1'b0, 1, 1'b0, 0);
        push(1'b1, 1'b0, 2, 1'b0, 0);
        push(1'b1, 1'b0, 3, 1'b0, 0);
        push(1'b0, 1'b1, 2, 1'b0, 0);
        push(1'b0, 1'b0, 2, 1'b0, 0);
        push(1'b0, 1'b0, 2, 1'b1, 1);
        for (int i = 0; i < 6; i++) push(1'b0, 1'b0, 2, 1'b0, 1);
        run_table("redcut");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lane_car_queue.md
Name: lane_car_queue

Overview:
- Consumer end of the car-arrival interface: absorbs the per-cycle add-car strobe from the random arrival generator and models the waiting queue for one approach.
- Discharges cars through the intersection at a paced rate while that approach's light is green.
- Outputs (queue depth, waiting flag, departure pulse, throughput count) feed the light controller and the display logic.

Parameters:
- MAX_CARS, 15, queue capacity in cars (1..255).
- CNT_W, 4, width of car_count; must satisfy 2^CNT_W > MAX_CARS.
- DEPART_CYCLES, 2, traffic_clk cycles a car occupies the intersection (>=1).
- GAP_CYCLES, 1, headway cycles after each departure before the next car may enter (>=0).

Ports:
- traffic_clk  input  1  traffic clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- add_car  input  1  arrival strobe; each cycle sampled high = one car arriving.
- light_green  input  1  this approach's light is green.
- car_count  output  CNT_W  cars currently waiting (excludes the car in the intersection).
- car_waiting  output  1  car_count != 0.
- queue_full  output  1  car_count == MAX_CARS.
- car_depart  output  1  one-cycle pulse per car cleared.
- cars_passed  output  8  total departures, wraps 255->0.

Behaviour:
- Reset: asserting reset_n low immediately forces state IDLE, timer 0, car_count 0, car_depart 0, cars_passed 0, and drop_count 0 when the optional feature is built in. Reset applies at any point, including mid-CROSS. The car in the intersection is discarded and no depart pulse follows.
- car_waiting and queue_full are decoded combinationally from registered car_count. All other outputs are registered.
- FSM states: IDLE, CROSS, GAP.
- IDLE:
  - At an edge with light_green=1 and car_count>0, go to CROSS and load the timer.
  - The car entering the intersection is removed from car_count on that same edge (count -1).
- CROSS:
  - Lasts exactly DEPART_CYCLES cycles and ignores light_green; a committed car always completes.
  - On the final CROSS edge, car_depart=1 for the next cycle and cars_passed increments.
  - Next state is GAP if GAP_CYCLES>0, else it follows the IDLE entry rule directly.
- GAP:
  - Lasts GAP_CYCLES cycles.
  - On the final edge, go to CROSS (with count -1) if light_green=1 and car_count>0, else IDLE.
- Steady green throughput: one car per DEPART_CYCLES+GAP_CYCLES cycles (3 at defaults).
- Count update per edge: next = count + accept - take. take = a car entering CROSS. accept = add_car && (count<MAX_CARS || take).
- Simultaneous arrival and entry leaves the count unchanged.
- Arrival at full with no take that edge is dropped; the count stays MAX_CARS.
- car_count never underflows; take requires count>0.
- light_green falling in IDLE or GAP blocks the next entry. Arrivals are accepted regardless of light state.

Optional Feature:
- Macro: LANE_CAR_QUEUE_DROP_COUNT_EN.
- Defined: adds output drop_count [7:0], incremented on each dropped arrival. It saturates at 255 and is cleared by reset_n.
- Undefined: no drop_count port and no drop-tracking logic. Drops are silent.

Test Plan:
- Reset, light_green=0, add_car=1 for 5 cycles -> car_count=5, car_waiting=1, car_depart never asserted, cars_passed=0.
- From the count=5 state, hold light_green=1 with add_car=0 -> car_count drops to 4 on the first edge. Exactly 5 car_depart pulses follow, spaced 3 cycles apart. Final car_count=0, cars_passed=5, FSM returns to IDLE.
- light_green=0, add_car=1 for 20 cycles from empty -> car_count saturates at 15 and queue_full=1. With the macro defined, drop_count=5.
- Count=15, light_green=1 with add_car=1 held -> car_count stays 15 at every entry edge (simultaneous accept/take), no drops, car_depart every 3 cycles.
- Count=3, light_green deasserted one cycle after entering CROSS -> that car still departs (car_count=2, one car_depart pulse), then no further departures while red.
- reset_n pulsed low mid-CROSS, asynchronous to traffic_clk -> car_count, cars_passed and car_depart go to 0 before the next clock edge. No depart pulse occurs after release.
